// File: rtl/alu_pkg.sv
// Shared types for the registered ALU decode stage: field encodings,
// ALU/branch/immediate codes, and the decoded bundle carried through the skid buffer.
package alu_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL  = 6'h03,
    OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ = 6'h07,
    OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
    OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F, OP_LB   = 6'h20,
    OP_LH      = 6'h21, OP_LWL    = 6'h22, OP_LW    = 6'h23, OP_LBU  = 6'h24,
    OP_LHU     = 6'h25, OP_LWR    = 6'h26, OP_SB    = 6'h28, OP_SH   = 6'h29,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04,
    FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09,
    FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13,
    FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B,
    FN_ADDU = 6'h21, FN_SUBU  = 6'h23, FN_AND  = 6'h24, FN_OR    = 6'h25,
    FN_XOR  = 6'h26, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B
  } func_t;

  typedef enum logic [4:0] {
    RI_BLTZ   = 5'h00, RI_BGEZ   = 5'h01,
    RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11
  } regimm_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND   = 4'd2,  ALU_OR   = 4'd3,
    ALU_XOR   = 4'd4,  ALU_SLT  = 4'd5,  ALU_SLTU  = 4'd6,  ALU_SLL  = 4'd7,
    ALU_SRL   = 4'd8,  ALU_SRA  = 4'd9,  ALU_MULT  = 4'd10, ALU_MULTU = 4'd11,
    ALU_DIV   = 4'd12, ALU_DIVU = 4'd13, ALU_BRANCH = 4'd14
  } alu_control_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LTZ = 3'd3,
    BR_GTZ  = 3'd4, BR_LEZ = 3'd5, BR_GEZ = 3'd6
  } branch_cond_t;

  typedef enum logic [1:0] {
    IMM_NONE = 2'b00, IMM_SIGN = 2'b01, IMM_ZERO = 2'b10, IMM_SHAMT = 2'b11
  } imm_mode_t;

  typedef struct packed {
    alu_control_t alu;
    branch_cond_t branch_cond;
    imm_mode_t    imm_mode;
    logic         illegal;
  } decoded_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational MIPS decode: instruction word to ALU control bundle,
// plus flags marking multi-cycle MULT/DIV issue and any HI/LO consumer.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec,
  output logic        is_muldiv,
  output logic        uses_hilo
);

  logic illegal;
  logic unused_fields;

  // Register numbers and immediates do not influence the decode.
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  always_comb begin
    dec       = '{alu: ALU_ADD, branch_cond: BR_NONE, imm_mode: IMM_NONE, illegal: 1'b0};
    is_muldiv = 1'b0;
    uses_hilo = 1'b0;
    illegal   = 1'b0;

    case (opcode_t'(instr[31:26]))
      OP_SPECIAL: begin
        case (func_t'(instr[5:0]))
          FN_SLL:   begin dec.alu = ALU_SLL; dec.imm_mode = IMM_SHAMT; end
          FN_SRL:   begin dec.alu = ALU_SRL; dec.imm_mode = IMM_SHAMT; end
          FN_SRA:   begin dec.alu = ALU_SRA; dec.imm_mode = IMM_SHAMT; end
          FN_SLLV:  dec.alu = ALU_SLL;
          FN_SRLV:  dec.alu = ALU_SRL;
          FN_SRAV:  dec.alu = ALU_SRA;
          FN_JR, FN_JALR: dec.alu = ALU_ADD;
          FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: uses_hilo = 1'b1;
          FN_MULT:  begin dec.alu = ALU_MULT;  is_muldiv = 1'b1; uses_hilo = 1'b1; end
          FN_MULTU: begin dec.alu = ALU_MULTU; is_muldiv = 1'b1; uses_hilo = 1'b1; end
          FN_DIV:   begin dec.alu = ALU_DIV;   is_muldiv = 1'b1; uses_hilo = 1'b1; end
          FN_DIVU:  begin dec.alu = ALU_DIVU;  is_muldiv = 1'b1; uses_hilo = 1'b1; end
          FN_ADDU:  dec.alu = ALU_ADD;
          FN_SUBU:  dec.alu = ALU_SUB;
          FN_AND:   dec.alu = ALU_AND;
          FN_OR:    dec.alu = ALU_OR;
          FN_XOR:   dec.alu = ALU_XOR;
          FN_SLT:   dec.alu = ALU_SLT;
          FN_SLTU:  dec.alu = ALU_SLTU;
          default:  illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        dec.alu      = ALU_BRANCH;
        dec.imm_mode = IMM_SIGN;
        case (regimm_t'(instr[20:16]))
          RI_BLTZ, RI_BLTZAL: dec.branch_cond = BR_LTZ;
          RI_BGEZ, RI_BGEZAL: dec.branch_cond = BR_GEZ;
          default:            illegal = 1'b1;
        endcase
      end
      OP_J, OP_JAL: dec.alu = ALU_ADD;
      OP_BEQ:  begin dec.alu = ALU_BRANCH; dec.imm_mode = IMM_SIGN; dec.branch_cond = BR_EQ;  end
      OP_BNE:  begin dec.alu = ALU_BRANCH; dec.imm_mode = IMM_SIGN; dec.branch_cond = BR_NE;  end
      OP_BLEZ: begin dec.alu = ALU_BRANCH; dec.imm_mode = IMM_SIGN; dec.branch_cond = BR_LEZ; end
      OP_BGTZ: begin dec.alu = ALU_BRANCH; dec.imm_mode = IMM_SIGN; dec.branch_cond = BR_GTZ; end
      OP_ADDIU, OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SW: begin dec.alu = ALU_ADD; dec.imm_mode = IMM_SIGN; end
      OP_SLTI:  begin dec.alu = ALU_SLT;  dec.imm_mode = IMM_SIGN; end
      OP_SLTIU: begin dec.alu = ALU_SLTU; dec.imm_mode = IMM_SIGN; end
      OP_ANDI:  begin dec.alu = ALU_AND;  dec.imm_mode = IMM_ZERO; end
      OP_ORI:   begin dec.alu = ALU_OR;   dec.imm_mode = IMM_ZERO; end
      OP_XORI:  begin dec.alu = ALU_XOR;  dec.imm_mode = IMM_ZERO; end
      OP_LUI:   begin dec.alu = ALU_ADD;  dec.imm_mode = IMM_ZERO; end
      default:  illegal = 1'b1;
    endcase

    // Unsupported words still flow, but with a fixed neutral bundle.
    if (illegal) begin
      dec       = '{alu: ALU_ADD, branch_cond: BR_NONE, imm_mode: IMM_NONE, illegal: 1'b1};
      is_muldiv = 1'b0;
      uses_hilo = 1'b0;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: head + skid slot behind a valid/ready handshake,
// with a HI/LO busy counter that holds back HI/LO users while MULT/DIV runs.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 4,
  parameter int unsigned DIV_LATENCY  = 33,
  parameter int unsigned CNT_WIDTH    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_control,
  output logic [2:0]  out_branch_cond,
  output logic [1:0]  out_imm_mode,
  output logic        out_illegal,
  output logic        hilo_busy
);

  typedef struct packed {
    decoded_t dec;
    logic     is_muldiv;
    logic     uses_hilo;
  } slot_t;

  localparam logic [CNT_WIDTH-1:0] MULT_LOAD = CNT_WIDTH'(MULT_LATENCY);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(DIV_LATENCY);

  slot_t                incoming;
  slot_t                head;
  slot_t                skid;
  logic                 head_full;
  logic                 skid_full;
  logic [CNT_WIDTH-1:0] busy_cnt;
  logic                 stall;
  logic                 accept;
  logic                 drain;
  logic                 head_open;

  alu_decode_comb u_decode (
    .instr     (in_instr),
    .dec       (incoming.dec),
    .is_muldiv (incoming.is_muldiv),
    .uses_hilo (incoming.uses_hilo)
  );

  assign hilo_busy = (busy_cnt != '0);
  assign stall     = hilo_busy && head.uses_hilo;
  assign out_valid = head_full && !stall;
  assign in_ready  = !skid_full && !reset;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign head_open = !head_full || drain;

  assign out_alu_control = head.dec.alu;
  assign out_branch_cond = head.dec.branch_cond;
  assign out_imm_mode    = head.dec.imm_mode;
  assign out_illegal     = head.dec.illegal;

  // A full skid blocks acceptance, so accept and skid refill never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      skid      <= '0;
      head_full <= 1'b0;
      skid_full <= 1'b0;
    end else if (skid_full) begin
      if (drain) begin
        head      <= skid;
        skid_full <= 1'b0;
      end
    end else if (accept) begin
      if (head_open) begin
        head      <= incoming;
        head_full <= 1'b1;
      end else begin
        skid      <= incoming;
        skid_full <= 1'b1;
      end
    end else if (drain) begin
      head_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (drain && head.is_muldiv) begin
      busy_cnt <= (head.dec.alu inside {ALU_MULT, ALU_MULTU}) ? MULT_LOAD : DIV_LOAD;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: accepted words push a reference
// decode; a negedge monitor checks handshake, HI/LO busy timing and fields.
module tb_alu_decode_stage;

  localparam int unsigned ML = 4;
  localparam int unsigned DL = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_alu_control;
  logic [2:0]  out_branch_cond;
  logic [1:0]  out_imm_mode;
  logic        out_illegal;
  logic        hilo_busy;

  alu_decode_stage #(.MULT_LATENCY(ML), .DIV_LATENCY(DL), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_control(out_alu_control), .out_branch_cond(out_branch_cond),
    .out_imm_mode(out_imm_mode), .out_illegal(out_illegal), .hilo_busy(hilo_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [2:0]  br;
    logic [1:0]  imm;
    logic        ill;
    logic        hilo;
    logic [6:0]  lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned model_cnt = 0;
  int          ready_mode = 0;
  logic        started = 1'b0;

  // Reference tables: opcode and funct properties listed directly from the ISA rules.
  logic        op_ok[64];
  logic [3:0]  op_alu[64];
  logic [1:0]  op_imm[64];
  logic [2:0]  op_br[64];
  logic        fn_ok[64];
  logic [3:0]  fn_alu[64];
  logic [1:0]  fn_imm[64];
  logic        fn_hilo[64];
  logic [6:0]  fn_lat[64];

  int unsigned fn_list[23] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h09, 'h10, 'h11, 'h12,
                               'h13, 'h18, 'h19, 'h1A, 'h1B, 'h21, 'h23, 'h24, 'h25, 'h26, 'h2A, 'h2B};
  int unsigned op_list[24] = '{'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E,
                               'h0F, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h28, 'h29, 'h2B, 'h08};

  function automatic void def_op(int unsigned op, int unsigned alu, int unsigned imm, int unsigned br);
    op_ok[op] = 1'b1; op_alu[op] = 4'(alu); op_imm[op] = 2'(imm); op_br[op] = 3'(br);
  endfunction

  function automatic void def_fn(int unsigned fn, int unsigned alu, int unsigned imm,
                                 int unsigned hilo, int unsigned lat);
    fn_ok[fn] = 1'b1; fn_alu[fn] = 4'(alu); fn_imm[fn] = 2'(imm);
    fn_hilo[fn] = 1'(hilo); fn_lat[fn] = 7'(lat);
  endfunction

  function automatic void build_tables();
    for (int i = 0; i < 64; i++) begin
      op_ok[i] = 1'b0; fn_ok[i] = 1'b0;
      op_alu[i] = '0; op_imm[i] = '0; op_br[i] = '0;
      fn_alu[i] = '0; fn_imm[i] = '0; fn_hilo[i] = 1'b0; fn_lat[i] = '0;
    end
    def_op('h02, 0, 0, 0);  def_op('h03, 0, 0, 0);
    def_op('h04, 14, 1, 1); def_op('h05, 14, 1, 2); def_op('h06, 14, 1, 5); def_op('h07, 14, 1, 4);
    def_op('h09, 0, 1, 0);  def_op('h0A, 5, 1, 0);  def_op('h0B, 6, 1, 0);
    def_op('h0C, 2, 2, 0);  def_op('h0D, 3, 2, 0);  def_op('h0E, 4, 2, 0);  def_op('h0F, 0, 2, 0);
    foreach (op_list[k]) if (op_list[k] >= 'h20) def_op(op_list[k], 0, 1, 0);
    def_fn('h00, 7, 3, 0, 0); def_fn('h02, 8, 3, 0, 0); def_fn('h03, 9, 3, 0, 0);
    def_fn('h04, 7, 0, 0, 0); def_fn('h06, 8, 0, 0, 0); def_fn('h07, 9, 0, 0, 0);
    def_fn('h08, 0, 0, 0, 0); def_fn('h09, 0, 0, 0, 0);
    for (int unsigned f = 'h10; f <= 'h13; f++) def_fn(f, 0, 0, 1, 0);
    def_fn('h18, 10, 0, 1, ML); def_fn('h19, 11, 0, 1, ML);
    def_fn('h1A, 12, 0, 1, DL); def_fn('h1B, 13, 0, 1, DL);
    def_fn('h21, 0, 0, 0, 0); def_fn('h23, 1, 0, 0, 0); def_fn('h24, 2, 0, 0, 0);
    def_fn('h25, 3, 0, 0, 0); def_fn('h26, 4, 0, 0, 0); def_fn('h2A, 5, 0, 0, 0); def_fn('h2B, 6, 0, 0, 0);
  endfunction

  function automatic exp_t model(logic [31:0] w);
    exp_t        e;
    int unsigned op = w[31:26];
    int unsigned fn = w[5:0];
    int unsigned rt = w[20:16];
    logic        bad = 1'b0;
    e = '0;
    e.instr = w;
    if (op == 0) begin
      if (fn_ok[fn]) begin
        e.alu = fn_alu[fn]; e.imm = fn_imm[fn]; e.hilo = fn_hilo[fn]; e.lat = fn_lat[fn];
      end else bad = 1'b1;
    end else if (op == 1) begin
      e.alu = 4'd14; e.imm = 2'd1;
      if (rt == 0 || rt == 16) e.br = 3'd3;
      else if (rt == 1 || rt == 17) e.br = 3'd6;
      else bad = 1'b1;
    end else if (op_ok[op]) begin
      e.alu = op_alu[op]; e.imm = op_imm[op]; e.br = op_br[op];
    end else bad = 1'b1;
    if (bad) begin
      e.alu = '0; e.br = '0; e.imm = '0; e.hilo = 1'b0; e.lat = '0; e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: DUT state seen here reflects every edge so far; the queue holds
  // exactly the words the DUT should be carrying.
  exp_t mon_front;
  logic mon_exp_valid;
  logic [6:0] mon_load;
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, !reset && (q.size() < 2));
      mon_exp_valid = (q.size() > 0) && !((model_cnt != 0) && q[0].hilo);
      chk("out_valid", out_valid, mon_exp_valid);
      chk("hilo_busy", hilo_busy, model_cnt != 0);
      mon_load = '0;
      if (out_valid && out_ready && !reset) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got alu %0h with empty scoreboard, expected none", out_alu_control);
        end else begin
          mon_front = q.pop_front();
          chk($sformatf("alu[%h]", mon_front.instr), out_alu_control, mon_front.alu);
          chk($sformatf("branch_cond[%h]", mon_front.instr), out_branch_cond, mon_front.br);
          chk($sformatf("imm_mode[%h]", mon_front.instr), out_imm_mode, mon_front.imm);
          chk($sformatf("illegal[%h]", mon_front.instr), out_illegal, mon_front.ill);
          mon_load = mon_front.lat;
        end
      end
      if (reset) begin
        q.delete();
        model_cnt = 0;
      end else if (mon_load != 0) model_cnt = mon_load;
      else if (model_cnt != 0) model_cnt--;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [31:0] w);
    int unsigned tries = 0;
    logic done = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    while (!done) begin
      @(negedge clk); #1;
      if (in_ready) begin
        q.push_back(model(w));
        done = 1'b1;
      end else if (++tries > 500) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected acceptance of %h", tries, w);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    int unsigned sel = $urandom_range(0, 9);
    logic [31:0] w = $urandom;
    if (sel == 0) return w;
    if (sel <= 3) begin
      w[31:26] = 6'h00; w[5:0] = 6'(fn_list[$urandom_range(0, 22)]);
    end else if (sel == 4) begin
      w[31:26] = 6'h01;
      w[20:16] = ($urandom_range(0, 4) == 0) ? 5'($urandom) : (($urandom_range(0, 1) == 1) ? 5'h10 : 5'h00) |
                 5'($urandom_range(0, 1));
    end else begin
      w[31:26] = 6'(op_list[$urandom_range(0, 23)]);
    end
    return w;
  endfunction

  initial begin
    build_tables();
    @(posedge clk); #1;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_alu", out_alu_control, 4'd0);
    chk("reset_branch", out_branch_cond, 3'd0);
    chk("reset_imm", out_imm_mode, 2'd0);
    chk("reset_illegal", out_illegal, 1'b0);
    @(posedge clk); #1;

    ready_mode = 0;
    send(32'h00851021); send(32'h34A2FFFF); idle(3);
    send(32'h00850018); send(32'h00001012); idle(10);

    ready_mode = 1;
    @(posedge clk); #1;
    send(32'h00851021); send(32'h00851023);
    fork
      send(32'h00851026);
      begin repeat (4) @(negedge clk); ready_mode = 0; end
    join
    idle(4);

    send(32'h04900003); send(32'h04820000); send(32'hFC000000); idle(3);

    send(32'h0085001B); send(32'h00001010); send(32'h00851021);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", hilo_busy, 1'b0);
    chk("post_reset_valid", out_valid, 1'b0);
    chk("post_reset_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      send(rand_word());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    ready_mode = 0;
    in_valid = 1'b0;
    for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
Registered, flow-controlled successor to the single-cycle ALU decoder. It accepts one 32-bit MIPS instruction per cycle over a valid/ready handshake and emits the ALU control, a 3-bit branch condition, an immediate-extension mode and an illegal flag. A 2-entry skid buffer decouples it from backpressure, and a HI/LO scoreboard stalls HI/LO users while a multi-cycle MULT/DIV is in flight. It sits between instruction fetch and the execute stage.

Parameters:
MULT_LATENCY, 4, cycles HI/LO stays busy after a MULT/MULTU issues (1..63).
DIV_LATENCY, 33, cycles HI/LO stays busy after a DIV/DIVU issues (1..63).
CNT_WIDTH, 6, width of the busy counter; must hold max(MULT_LATENCY, DIV_LATENCY).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_instr is valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
out_valid  out  1  decoded result valid and not stalled
out_ready  in  1  execute stage accepts the result
out_alu_control  out  4  ALU op code (package enum)
out_branch_cond  out  3  branch condition code
out_imm_mode  out  2  00 none, 01 sign-extend, 10 zero-extend, 11 shamt
out_illegal  out  1  opcode, funct or REGIMM rt field not supported
hilo_busy  out  1  busy counter is non-zero

Behaviour:
- Reset: all outputs 0, skid empty, counter 0. in_ready is 0 while reset is high and 1 on the first cycle after reset.
- Decode is combinational on in_instr and is registered on acceptance (in_valid && in_ready). Latency is 1 cycle: the result is visible the cycle after acceptance when the head slot is empty or draining.
- Storage is a head register plus one skid register.
  - in_ready = !skid_full.
  - If the head is occupied and not draining, an accepted word goes to the skid slot.
  - When the head drains, skid moves into the head.
  - Order is always preserved.
- Head drains on out_valid && out_ready.
- out_valid = head_full && !stall.
  - stall = hilo_busy && head is one of MULT, MULTU, DIV, DIVU, MFHI(010000), MTHI(010001), MFLO(010010), MTLO(010011).
  - Head fields stay stable during a stall.
- Scoreboard counter:
  - When a MULT/MULTU drains, load MULT_LATENCY; when a DIV/DIVU drains, load DIV_LATENCY.
  - Otherwise, decrement when non-zero; hold at 0.
  - Load and decrement never coincide, because stall blocks issue while the counter is non-zero.
- ALU mapping:
  - R-type: ADDU→ADD, SUBU→SUB, AND, OR, XOR, SLT, SLTU; SLL/SLLV→SLL, SRL/SRLV→SRL, SRA/SRAV→SRA; MULT, MULTU, DIV, DIVU to their own codes.
  - ADDIU, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW → ADD.
  - ANDI→AND, ORI→OR, XORI→XOR, SLTI→SLT, SLTIU→SLTU.
  - BEQ, BNE, BGTZ, BLEZ, REGIMM → BRANCH.
  - J, JAL, JR, JALR, LUI, MFHI/MFLO/MTHI/MTLO → ADD. The code is deterministic for these; the decoder never holds a previous value.
- imm_mode:
  - Sign-extend: arithmetic/load/store/SLTI/SLTIU/branches.
  - Zero-extend: ANDI/ORI/XORI/LUI.
  - Shamt: SLL/SRL/SRA.
  - None: everything else.
- branch_cond: 000 none, 001 EQ (BEQ), 010 NE (BNE), 011 LTZ (BLTZ/BLTZAL), 100 GTZ (BGTZ), 101 LEZ (BLEZ), 110 GEZ (BGEZ/BGEZAL).
- Illegal:
  - Triggers: unknown opcode, unknown R-type funct, or REGIMM rt not in {00000, 00001, 10000, 10001}.
  - Response: out_illegal=1, alu=ADD, branch_cond=000, imm_mode=00. The word still flows normally.
- Reset mid-operation, including a non-zero counter or full skid, clears everything on the next edge; in-flight words are discarded.

Decomposition:
- Package alu_pkg holds: opcode_t, func_t, regimm_t, alu_control_t (4-bit, values identical to the existing decoder), branch_cond_t (3-bit), imm_mode_t.
- Sub-module alu_decode_comb: a pure combinational decode from instruction to the decoded bundle plus the is_muldiv and uses_hilo flags.
- alu_decode_stage holds the skid buffer, stall logic and counter.

Test Plan:
- ADDU 0x00851021, then ORI 0x34A2FFFF back-to-back with out_ready=1 → out_valid on cycles 1 and 2 with alu 0000/imm 00, then alu 0011/imm 10.
- MULT 0x00850018, then MFLO 0x00001012, MULT_LATENCY=4 → hilo_busy high 4 cycles; MFLO out_valid rises on the first cycle the counter reads 0.
- out_ready=0 with 3 words offered → 2 accepted, in_ready=0 on the cycle after the second acceptance; on release, the words drain in order with no loss or duplication.
- BLTZAL 0x04900003 → branch_cond 011, alu 1110. REGIMM rt=00010 (0x04820000) → out_illegal=1, branch_cond 000.
- Opcode 0x3F (0xFC000000) → out_illegal=1, alu 0000, the word still handshakes out.
- DIVU issued, reset asserted 5 cycles later → hilo_busy=0, out_valid=0, skid empty next cycle; in_ready=1 after reset is released.
